// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the EX-stage divider: op encodings, FSM states
// and a two's-complement helper.
package rv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    DIV_NONE = 3'd0,
    DIV_DIV  = 3'd1,
    DIV_DIVU = 3'd2,
    DIV_REM  = 3'd3,
    DIV_REMU = 3'd4
  } div_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one,
// then subtract the divisor if it fits and record the quotient bit.
module udiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh_s;

  // Shifted partial remainder needs one extra bit; the difference always fits XLEN.
  always_comb begin
    rem_sh_s = {rem_i, quo_i[XLEN-1]};
    if (rem_sh_s >= {1'b0, dvsr_i}) begin
      rem_o = rem_sh_s[XLEN-1:0] - dvsr_i;
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh_s[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage: 32 restoring steps,
// single-cycle special cases, combinational stall request, registered result.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            nrst,
  input  logic            load_hazard,
  input  logic            flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      div_op,
  output logic [XLEN-1:0] res,
  output logic            div_stall
);

  import rv_pkg::*;

  div_state_e      state_q, state_d;
  logic [4:0]      count_q, count_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            is_rem_q, is_rem_d;

  logic            is_div_s, is_signed_s, is_rem_s, ovf_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN-1:0] step_rem_s, step_quo_s;

  assign is_div_s    = (div_op >= 3'd1) && (div_op <= 3'd4);
  assign is_signed_s = (div_op == DIV_DIV) || (div_op == DIV_REM);
  assign is_rem_s    = (div_op == DIV_REM) || (div_op == DIV_REMU);
  assign ovf_s       = is_signed_s && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                       && (op_b == {XLEN{1'b1}});
  assign a_mag_s     = (is_signed_s && op_a[XLEN-1]) ? neg2c(op_a) : op_a;
  assign b_mag_s     = (is_signed_s && op_b[XLEN-1]) ? neg2c(op_b) : op_b;

  assign div_stall = is_div_s && (state_q != DIV_DONE);
  assign res       = res_q;

  udiv_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem_s),
    .quo_o (step_quo_s)
  );

  // Next-state and datapath update; flush aborts from any state without touching res.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    res_d     = res_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_rem_d  = is_rem_q;
    if (flush) begin
      state_d = DIV_IDLE;
      count_d = 5'd0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (is_div_s && !load_hazard) begin
            is_rem_d  = is_rem_s;
            neg_quo_d = (div_op == DIV_DIV) && (op_a[XLEN-1] ^ op_b[XLEN-1]);
            neg_rem_d = (div_op == DIV_REM) && op_a[XLEN-1];
            if (op_b == {XLEN{1'b0}}) begin
              res_d   = is_rem_s ? op_a : {XLEN{1'b1}};
              state_d = DIV_DONE;
            end else if (ovf_s) begin
              res_d   = is_rem_s ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
              state_d = DIV_DONE;
            end else begin
              rem_d   = {XLEN{1'b0}};
              quo_d   = a_mag_s;
              dvsr_d  = b_mag_s;
              count_d = 5'd0;
              state_d = DIV_BUSY;
            end
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          rem_d   = step_rem_s;
          quo_d   = step_quo_s;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            if (is_rem_q) begin
              res_d = neg_rem_q ? neg2c(step_rem_s) : step_rem_s;
            end else begin
              res_d = neg_quo_q ? neg2c(step_quo_s) : step_quo_s;
            end
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_BUSY;
          end
        end
        DIV_DONE: begin
          if (load_hazard) begin
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_IDLE;
          end
        end
        default: begin
          state_d = DIV_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      state_q   <= DIV_IDLE;
      count_q   <= 5'd0;
      rem_q     <= {XLEN{1'b0}};
      quo_q     <= {XLEN{1'b0}};
      dvsr_q    <= {XLEN{1'b0}};
      res_q     <= {XLEN{1'b0}};
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_rem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      res_q     <= res_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      is_rem_q  <= is_rem_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a vector table of ops with expected result and
// DONE cycle, plus sequences for hazard-in-DONE, flush and mid-divide reset.
module tb_div_unit;

  logic        CLK;
  logic        nrst;
  logic        load_hazard;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  div_op;
  logic [31:0] res;
  logic        div_stall;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          haz;
    logic [31:0] exp_res;
    int          exp_cyc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [0:NV-1];

  div_unit #(.XLEN(32)) dut (
    .CLK        (CLK),
    .nrst       (nrst),
    .load_hazard(load_hazard),
    .flush      (flush),
    .op_a       (op_a),
    .op_b       (op_b),
    .div_op     (div_op),
    .res        (res),
    .div_stall  (div_stall)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called just after the posedge of cycle 0; returns the cycle index where stall first drops.
  task automatic wait_done(input int h, output int cyc);
    cyc = -1;
    for (int c = 0; c < 200; c++) begin
      load_hazard = (c < h);
      @(negedge CLK);
      if (!div_stall) begin
        cyc = c;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int h, input logic [31:0] exp_res, input int exp_cyc,
                       input string name);
    int cyc;
    @(posedge CLK);
    #1;
    div_op = op;
    op_a   = a;
    op_b   = b;
    wait_done(h, cyc);
    chk({name, "_cycle"}, cyc, exp_cyc);
    chk({name, "_res"}, res, exp_res);
    @(posedge CLK);
    #1;
    div_op      = 3'd0;
    load_hazard = 1'b0;
  endtask

  initial begin
    int cyc;
    // op codes: 1 DIV, 2 DIVU, 3 REM, 4 REMU
    vecs[0]  = '{3'd2, 32'd100,        32'd7,          0, 32'd14,         33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFF,  33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFF9,  32'd2,          0, 32'hFFFF_FFFD,  33};
    vecs[3]  = '{3'd1, 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h8000_0000,  1};
    vecs[4]  = '{3'd3, 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h0000_0000,  1};
    vecs[5]  = '{3'd1, 32'd5,          32'd0,          0, 32'hFFFF_FFFF,  1};
    vecs[6]  = '{3'd4, 32'd5,          32'd0,          0, 32'd5,          1};
    vecs[7]  = '{3'd2, 32'd9,          32'd3,          2, 32'd3,          35};
    vecs[8]  = '{3'd4, 32'd100,        32'd7,          0, 32'd2,          33};
    vecs[9]  = '{3'd1, 32'd7,          32'hFFFF_FFFE,  0, 32'hFFFF_FFFD,  33};
    vecs[10] = '{3'd3, 32'd7,          32'hFFFF_FFFE,  0, 32'd1,          33};
    vecs[11] = '{3'd2, 32'hFFFF_FFFF,  32'd1,          0, 32'hFFFF_FFFF,  33};
    vecs[12] = '{3'd3, 32'hFFFF_FF9C,  32'd7,          0, 32'hFFFF_FFFE,  33};
    vecs[13] = '{3'd1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  0, 32'd14,         33};
    vecs[14] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'd0,          33};
    vecs[15] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'h8000_0000,  33};
    vecs[16] = '{3'd1, 32'd0,          32'hFFFF_FFFF,  0, 32'd0,          33};
    vecs[17] = '{3'd2, 32'd0,          32'd0,          0, 32'hFFFF_FFFF,  1};
    vecs[18] = '{3'd2, 32'd3,          32'd5,          0, 32'd0,          33};
    vecs[19] = '{3'd3, 32'hFFFF_FFF9,  32'd0,          0, 32'hFFFF_FFF9,  1};
    vecs[20] = '{3'd1, 32'd5,          32'd0,          3, 32'hFFFF_FFFF,  4};

    nrst        = 1'b0;
    load_hazard = 1'b0;
    flush       = 1'b0;
    op_a        = 32'd0;
    op_b        = 32'd0;
    div_op      = 3'd0;

    // Reset values; stall follows div_op even while reset is held.
    repeat (3) @(posedge CLK);
    #1;
    @(negedge CLK);
    chk("reset_res", res, 32'd0);
    chk("reset_stall_none", {31'd0, div_stall}, 32'd0);
    div_op = 3'd1;
    #1;
    chk("reset_stall_div", {31'd0, div_stall}, 32'd1);
    @(posedge CLK);
    #1;
    div_op = 3'd0;
    nrst   = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].haz, vecs[i].exp_res,
            vecs[i].exp_cyc, $sformatf("vec%0d", i));
    end

    // load_hazard held through DONE: stays in DONE with res stable and stall low.
    @(posedge CLK);
    #1;
    div_op = 3'd2;
    op_a   = 32'd20;
    op_b   = 32'd4;
    wait_done(0, cyc);
    chk("hold_cycle", cyc, 33);
    chk("hold_res", res, 32'd5);
    load_hazard = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk($sformatf("hold_stall%0d", k), {31'd0, div_stall}, 32'd0);
      chk($sformatf("hold_res%0d", k), res, 32'd5);
    end
    load_hazard = 1'b0;
    @(posedge CLK);
    #1;
    div_op = 3'd0;

    // Flush in cycle 10 aborts; res keeps its old value.
    @(posedge CLK);
    #1;
    div_op = 3'd2;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    repeat (10) @(posedge CLK);
    #1;
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_stall_c10", {31'd0, div_stall}, 32'd1);
    @(posedge CLK);
    #1;
    flush  = 1'b0;
    div_op = 3'd0;
    @(negedge CLK);
    chk("flush_stall_c11", {31'd0, div_stall}, 32'd0);
    chk("flush_res_c11", res, 32'd5);
    repeat (30) @(posedge CLK);
    @(negedge CLK);
    chk("flush_res_late", res, 32'd5);
    issue(3'd2, 32'd1, 32'd1, 0, 32'd1, 33, "after_flush");

    // Reset mid-BUSY: next cycle res is 0 and stall follows div_op, then a full restart.
    @(posedge CLK);
    #1;
    div_op = 3'd2;
    op_a   = 32'd100;
    op_b   = 32'd7;
    repeat (5) @(posedge CLK);
    #1;
    nrst = 1'b0;
    @(posedge CLK);
    #1;
    nrst        = 1'b1;
    load_hazard = 1'b1;
    @(negedge CLK);
    chk("rst_busy_res", res, 32'd0);
    chk("rst_busy_stall", {31'd0, div_stall}, 32'd1);
    @(posedge CLK);
    #1;
    wait_done(0, cyc);
    chk("rst_restart_cycle", cyc, 33);
    chk("rst_restart_res", res, 32'd14);
    @(posedge CLK);
    #1;
    div_op = 3'd0;
    @(negedge CLK);
    chk("final_idle_stall", {31'd0, div_stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits in the EX stage beside the ALU and takes the same forwarded `op_a`/`op_b` operands. It stalls the pipeline while it iterates. Its registered result is selected into the EX result path in place of the ALU result when a divide op is present.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports:
- `CLK` (in, 1): clock.
- `nrst` (in, 1): synchronous, active-low reset.
- `load_hazard` (in, 1): operands are not yet valid and the pipeline is frozen. The block must not start or retire while this is high.
- `flush` (in, 1): EX-stage flush from a branch or jump. Aborts any divide in progress.
- `op_a` (in, 32): dividend.
- `op_b` (in, 32): divisor.
- `div_op` (in, 3): 0 = none, 1 = DIV, 2 = DIVU, 3 = REM, 4 = REMU. Values 5–7 are treated as none. Held stable by the pipeline while `div_stall` is high.
- `res` (out, 32): quotient or remainder. Valid only in state DONE. Reset value 0.
- `div_stall` (out, 1): stall request to the hazard logic. Reset value follows `div_op` (combinational).

## Operation
- `is_div` = `div_op` is in 1..4.
- `div_stall` = `is_div` AND state != DONE. It is combinational, so it is high in the same cycle the op first appears.
- **IDLE**: if `is_div`, not `load_hazard`, and not `flush`:
  - Latch operands and op, and record sign flags.
  - Divide by zero (`op_b` = 0): `res` ← 0xFFFFFFFF for DIV/DIVU, `res` ← `op_a` for REM/REMU. Go to DONE.
  - Signed overflow (DIV/REM with `op_a` = 0x80000000, `op_b` = 0xFFFFFFFF): `res` ← 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise: load |a| and |b| (magnitudes for signed ops, raw for unsigned), clear remainder, count ← 0, go to BUSY.
- **BUSY**: one restoring-division step per cycle:
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor, subtract the divisor and set quo[0].
  - count increments. After the step with count = 31, apply the sign fix, write `res`, and go to DONE.
- **Sign fix**:
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - The fix is applied as a two's-complement negate of the magnitude.
- **DONE**: `res` is valid and `div_stall` is low.
  - If `load_hazard` is high, stay in DONE (the pipeline did not advance).
  - Otherwise go to IDLE next cycle.
- `flush` in any state: next state is IDLE, count ← 0, and `res` is unchanged. `flush` has priority over starting an op.
- `nrst` low: state IDLE, count 0, `res` 0. This has priority over everything, including mid-BUSY.
- A back-to-back divide restarts from IDLE in the cycle after DONE. `div_stall` rises again immediately because state is IDLE.

## Timing
- Normal divide:
  - Op appears in cycle 0 and is latched at the end of cycle 0.
  - BUSY runs cycles 1–32.
  - DONE is cycle 33: `res` valid, stall low.
  - Stall is high for exactly 33 cycles.
- Special cases (divide by zero, overflow): DONE in cycle 1. Stall is high for 1 cycle, matching the multiplier's single-cycle stall.
- If `load_hazard` is high in cycle 0, the start slips one cycle per hazard cycle.
- `res` is registered. There is no combinational path from `op_a`/`op_b` to `res`.

## Structure
- Shared package `rv_pkg`:
  - `div_op` encodings: `DIV_NONE`, `DIV_DIV`, `DIV_DIVU`, `DIV_REM`, `DIV_REMU`.
  - FSM state encodings: `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`.
  - `XLEN`.
- One natural sub-module, `udiv_step`: a combinational single restoring-division step taking {rem, quo, divisor} and returning {rem', quo'}. It is instantiated once in `div_unit`. Sign handling, special cases and the FSM stay in `div_unit`.

## Test plan
- DIVU 100 / 7 → `res` = 14 in cycle 33; `div_stall` high cycles 0–32 then low; state IDLE in cycle 34.
- REM −7 (0xFFFFFFF9) % 2 → 0xFFFFFFFF; DIV −7 / 2 → 0xFFFFFFFD; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1 with a 1-cycle stall.
- Divide by zero: DIV 5 / 0 → 0xFFFFFFFF and REMU 5 % 0 → 5, each ready in cycle 1.
- `load_hazard` high in cycles 0–1 with DIVU 9 / 3 → no start until cycle 2; `res` = 3 at cycle 35. `load_hazard` high during DONE → DONE and `res` held.
- `flush` in cycle 10 of a divide → IDLE in cycle 11, `res` unchanged. Then DIVU 1 / 1 issued → `res` = 1 after a full 33-cycle stall.
- `nrst` low mid-BUSY → next cycle: state IDLE, `res` = 0, `div_stall` = `is_div`.
